mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 SHALL have port i_CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port i_RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports i_A_Req / i_B_Req  input  1  requester A (CPU) / B (loader/DMA) transaction request, level.
REQ-006 SHALL have ports i_A_Write_EN / i_B_Write_EN  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports i_A_Address / i_B_Address  input  ADDR_W  target address.
REQ-008 SHALL have ports i_A_Data / i_B_Data  input  DATA_W  write data.
REQ-009 SHALL have ports o_A_Grant / o_B_Grant  output  1  request accepted this cycle (combinational).
REQ-010 SHALL have ports o_A_Ack / o_B_Ack  output  1  one-cycle completion pulse, registered.
REQ-011 SHALL have ports o_A_Rd_Data / o_B_Rd_Data  output  DATA_W  read result, valid with Ack.
REQ-012 SHALL have ports o_Mem_Address  output  ADDR_W, o_Mem_Data  output  DATA_W, o_Mem_Write_EN  output  1, i_Mem_Data  input  DATA_W  shared memory port, memory read data valid one cycle after address.

Function
REQ-013 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, one cycle per state, no wait states.
REQ-014 SHALL assert at most one Grant, only in IDLE, only for a requester with Req high; handshake = Req & Grant in same cycle.
REQ-015 SHALL on handshake latch winner ID, Address, Data, Write_EN, and go to ADDR; no handshake keeps IDLE.
REQ-016 SHALL drive o_Mem_Address/o_Mem_Data from latched values in ADDR and DATA; o_Mem_Write_EN high only in ADDR of a write; otherwise 0.
REQ-017 SHALL on a read capture i_Mem_Data at end of DATA into winner's Rd_Data; other Rd_Data unchanged; on a write both Rd_Data unchanged.
REQ-018 SHALL pulse winner's Ack for exactly one cycle, the cycle after DATA (3 cycles after handshake cycle).
REQ-019 SHALL allow a new handshake in the Ack cycle (FSM is IDLE), giving 3-cycle back-to-back throughput.
REQ-020 SHALL ignore Req while not IDLE; requester holds Req and its fields until Grant.
REQ-021 SHALL with both Req high in IDLE resolve per REQ-026/REQ-027; a single Req is always granted immediately.
REQ-022 SHALL drive o_Mem_Address and o_Mem_Data as 0 in IDLE.

Reset
REQ-023 SHALL on i_RESET high immediately force IDLE, Grants 0, Acks 0, o_Mem_Write_EN 0, latched fields 0, Rd_Data 0, priority pointer = A.
REQ-024 SHALL abort an in-flight transaction on reset with no Ack; a write in ADDR is cut off asynchronously.
REQ-025 SHALL grant nothing in the first cycle after reset release unless Req is high then.

Configuration
REQ-026 SHALL with MEM_ARBITER_ROUND_ROBIN_EN defined use round-robin: on contention grant the requester not granted last; pointer updates on every handshake.
REQ-027 SHALL without MEM_ARBITER_ROUND_ROBIN_EN use fixed priority: A always wins contention; no pointer register.

Verification
REQ-028 SHALL verify: A write 0x1234 to 0x0010, B idle -> o_A_Grant cycle 0, o_Mem_Write_EN only cycle 1 with address 0x0010, o_A_Ack cycle 3, o_A_Rd_Data unchanged.
REQ-029 SHALL verify: after REQ-028, A read 0x0010 -> o_A_Ack cycle 3, o_A_Rd_Data = 0x1234, o_B_Rd_Data unchanged.
REQ-030 SHALL verify: A and B Req held high continuously, 4 transactions -> round-robin order A,B,A,B; without macro A,A,A,A; grants spaced 3 cycles.
REQ-031 SHALL verify: B Req rises during A's ADDR -> o_B_Grant low until A's Ack cycle, then granted that cycle.
REQ-032 SHALL verify: i_RESET pulsed during ADDR of a write -> o_Mem_Write_EN drops immediately, no Ack, FSM IDLE, Rd_Data 0.
REQ-033 SHALL verify: Req low on both ports for 10 cycles -> no Grant, no Ack, o_Mem_Write_EN 0, memory address/data 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory: IDLE -> ADDR -> DATA, Ack the cycle after DATA.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin contention; default is fixed priority (A wins).
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  input  logic              i_A_Req,
  input  logic              i_A_Write_EN,
  input  logic [ADDR_W-1:0] i_A_Address,
  input  logic [DATA_W-1:0] i_A_Data,
  output logic              o_A_Grant,
  output logic              o_A_Ack,
  output logic [DATA_W-1:0] o_A_Rd_Data,
  input  logic              i_B_Req,
  input  logic              i_B_Write_EN,
  input  logic [ADDR_W-1:0] i_B_Address,
  input  logic [DATA_W-1:0] i_B_Data,
  output logic              o_B_Grant,
  output logic              o_B_Ack,
  output logic [DATA_W-1:0] o_B_Rd_Data,
  output logic [ADDR_W-1:0] o_Mem_Address,
  output logic [DATA_W-1:0] o_Mem_Data,
  output logic              o_Mem_Write_EN,
  input  logic [DATA_W-1:0] i_Mem_Data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            state_q;
  logic              win_b_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              a_ack_q, b_ack_q;
  logic [DATA_W-1:0] a_rd_q, b_rd_q;
  logic              a_grant, b_grant;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic prio_b_q;  // 1: B wins the next contention
`endif

  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (state_q == S_IDLE) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (i_A_Req && i_B_Req) begin
        a_grant = ~prio_b_q;
        b_grant = prio_b_q;
      end else begin
        a_grant = i_A_Req;
        b_grant = i_B_Req;
      end
`else
      a_grant = i_A_Req;
      b_grant = i_B_Req & ~i_A_Req;
`endif
    end
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q  <= S_IDLE;
      win_b_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      a_rd_q   <= '0;
      b_rd_q   <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      prio_b_q <= 1'b0;
`endif
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (a_grant || b_grant) begin
            win_b_q <= b_grant;
            we_q    <= b_grant ? i_B_Write_EN : i_A_Write_EN;
            addr_q  <= b_grant ? i_B_Address  : i_A_Address;
            data_q  <= b_grant ? i_B_Data     : i_A_Data;
            state_q <= S_ADDR;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            prio_b_q <= a_grant;
`endif
          end
        end
        S_ADDR: state_q <= S_DATA;
        S_DATA: begin
          state_q <= S_IDLE;
          if (win_b_q) b_ack_q <= 1'b1;
          else         a_ack_q <= 1'b1;
          if (!we_q) begin
            if (win_b_q) b_rd_q <= i_Mem_Data;
            else         a_rd_q <= i_Mem_Data;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Decoded from state so an async reset drops the write strobe immediately
  assign o_Mem_Write_EN = (state_q == S_ADDR) && we_q;
  assign o_Mem_Address  = (state_q == S_IDLE) ? '0 : addr_q;
  assign o_Mem_Data     = (state_q == S_IDLE) ? '0 : data_q;

  assign o_A_Grant   = a_grant;
  assign o_B_Grant   = b_grant;
  assign o_A_Ack     = a_ack_q;
  assign o_B_Ack     = b_ack_q;
  assign o_A_Rd_Data = a_rd_q;
  assign o_B_Rd_Data = b_rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of granted transactions popped on Ack.
// Expected contention order follows MEM_ARBITER_ROUND_ROBIN_EN when defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_data, b_addr, b_data;
  logic        a_gnt, b_gnt, a_ack, b_ack;
  logic [15:0] a_rd, b_rd;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [15:0] mem [0:255];

  typedef struct {
    logic        is_b;
    logic        is_rd;
    logic [15:0] rd_val;
  } txn_t;

  txn_t        sb_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] exp_a_rd, exp_b_rd;

  always #5 clk = ~clk;

  // Memory: write on the ADDR edge, read data valid one cycle after the address
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .i_CLK(clk), .i_RESET(rst),
    .i_A_Req(a_req), .i_A_Write_EN(a_we), .i_A_Address(a_addr), .i_A_Data(a_data),
    .o_A_Grant(a_gnt), .o_A_Ack(a_ack), .o_A_Rd_Data(a_rd),
    .i_B_Req(b_req), .i_B_Write_EN(b_we), .i_B_Address(b_addr), .i_B_Data(b_data),
    .o_B_Grant(b_gnt), .o_B_Ack(b_ack), .o_B_Rd_Data(b_rd),
    .o_Mem_Address(mem_addr), .o_Mem_Data(mem_wdata), .o_Mem_Write_EN(mem_we),
    .i_Mem_Data(mem_rdata)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic is_b, input logic is_rd, input logic [15:0] v);
    txn_t t;
    t.is_b = is_b; t.is_rd = is_rd; t.rd_val = v;
    sb_q.push_back(t);
  endtask

  task automatic sb_pop(output logic is_b, output logic ok);
    txn_t t;
    if (sb_q.size() == 0) begin
      ok = 1'b0; is_b = 1'b0;
    end else begin
      t = sb_q.pop_front();
      ok = 1'b1; is_b = t.is_b;
      if (t.is_rd) begin
        if (t.is_b) exp_b_rd = t.rd_val;
        else        exp_a_rd = t.rd_val;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_data = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_data = 0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL rst_grant got %b want 00", {a_gnt, b_gnt}); else pass_cnt++;
    total_cnt++; if ({a_ack, b_ack} !== 2'b00) $display("FAIL rst_ack got %b want 00", {a_ack, b_ack}); else pass_cnt++;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL rst_we got %b want 0", mem_we); else pass_cnt++;
    total_cnt++; if ({mem_addr, mem_wdata} !== 32'h0) $display("FAIL rst_mem got %h want 0", {mem_addr, mem_wdata}); else pass_cnt++;
    total_cnt++; if ({a_rd, b_rd} !== 32'h0) $display("FAIL rst_rd got %h want 0", {a_rd, b_rd}); else pass_cnt++;
    step; rst = 1'b0;
    exp_a_rd = 16'h0; exp_b_rd = 16'h0;
    sb_q.delete();
    step;
    total_cnt++; if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL post_rst_grant got %b want 00", {a_gnt, b_gnt}); else pass_cnt++;
  endtask

  task automatic test_write;
    logic wb, ok;
    step;
    a_req = 1; a_we = 1; a_addr = 16'h0010; a_data = 16'h1234;
    #1;
    total_cnt++; if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL wr_grant got %b want 10", {a_gnt, b_gnt}); else pass_cnt++;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL wr_we_c0 got %b want 0", mem_we); else pass_cnt++;
    sb_push(1'b0, 1'b0, 16'h0);
    step; a_req = 0; #1;
    total_cnt++; if (mem_we !== 1'b1) $display("FAIL wr_we_c1 got %b want 1", mem_we); else pass_cnt++;
    total_cnt++; if (mem_addr !== 16'h0010) $display("FAIL wr_addr_c1 got %h want 0010", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 16'h1234) $display("FAIL wr_data_c1 got %h want 1234", mem_wdata); else pass_cnt++;
    step;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL wr_we_c2 got %b want 0", mem_we); else pass_cnt++;
    total_cnt++; if ({a_ack, b_ack} !== 2'b00) $display("FAIL wr_ack_c2 got %b want 00", {a_ack, b_ack}); else pass_cnt++;
    step;
    sb_pop(wb, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL wr_sb got empty want entry"); else pass_cnt++;
    total_cnt++; if ({a_ack, b_ack} !== (wb ? 2'b01 : 2'b10)) $display("FAIL wr_ack_c3 got %b want %b", {a_ack, b_ack}, (wb ? 2'b01 : 2'b10)); else pass_cnt++;
    total_cnt++; if (a_rd !== exp_a_rd) $display("FAIL wr_a_rd got %h want %h", a_rd, exp_a_rd); else pass_cnt++;
    step;
    total_cnt++; if ({a_ack, b_ack} !== 2'b00) $display("FAIL wr_ack_c4 got %b want 00", {a_ack, b_ack}); else pass_cnt++;
  endtask

  task automatic test_read;
    logic wb, ok;
    step;
    a_req = 1; a_we = 0; a_addr = 16'h0010; a_data = 16'h0;
    #1;
    total_cnt++; if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL rd_grant got %b want 10", {a_gnt, b_gnt}); else pass_cnt++;
    sb_push(1'b0, 1'b1, 16'h1234);
    step; a_req = 0; #1;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL rd_we_c1 got %b want 0", mem_we); else pass_cnt++;
    total_cnt++; if (mem_addr !== 16'h0010) $display("FAIL rd_addr_c1 got %h want 0010", mem_addr); else pass_cnt++;
    step;
    step;
    sb_pop(wb, ok);
    total_cnt++; if ({ok, a_ack, b_ack} !== (wb ? 3'b101 : 3'b110)) $display("FAIL rd_ack_c3 got %b want %b", {ok, a_ack, b_ack}, (wb ? 3'b101 : 3'b110)); else pass_cnt++;
    total_cnt++; if (a_rd !== exp_a_rd) $display("FAIL rd_a_rd got %h want %h", a_rd, exp_a_rd); else pass_cnt++;
    total_cnt++; if (b_rd !== exp_b_rd) $display("FAIL rd_b_rd got %h want %h", b_rd, exp_b_rd); else pass_cnt++;
  endtask

  task automatic test_late_req;
    logic wb, ok;
    step;
    a_req = 1; a_we = 1; a_addr = 16'h0030; a_data = 16'h5555;
    #1;
    total_cnt++; if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL late_a_grant got %b want 10", {a_gnt, b_gnt}); else pass_cnt++;
    sb_push(1'b0, 1'b0, 16'h0);
    step;
    a_req = 0;
    b_req = 1; b_we = 0; b_addr = 16'h0030; b_data = 16'h0;
    #1;
    total_cnt++; if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL late_grant_c1 got %b want 00", {a_gnt, b_gnt}); else pass_cnt++;
    step;
    total_cnt++; if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL late_grant_c2 got %b want 00", {a_gnt, b_gnt}); else pass_cnt++;
    step;
    sb_pop(wb, ok);
    total_cnt++; if ({ok, a_ack, b_ack} !== (wb ? 3'b101 : 3'b110)) $display("FAIL late_a_ack got %b want %b", {ok, a_ack, b_ack}, (wb ? 3'b101 : 3'b110)); else pass_cnt++;
    total_cnt++; if ({a_gnt, b_gnt} !== 2'b01) $display("FAIL late_b_grant got %b want 01", {a_gnt, b_gnt}); else pass_cnt++;
    sb_push(1'b1, 1'b1, 16'h5555);
    step; b_req = 0;
    step;
    step;
    sb_pop(wb, ok);
    total_cnt++; if ({ok, a_ack, b_ack} !== (wb ? 3'b101 : 3'b110)) $display("FAIL late_b_ack got %b want %b", {ok, a_ack, b_ack}, (wb ? 3'b101 : 3'b110)); else pass_cnt++;
    total_cnt++; if (b_rd !== exp_b_rd) $display("FAIL late_b_rd got %h want %h", b_rd, exp_b_rd); else pass_cnt++;
    total_cnt++; if (a_rd !== exp_a_rd) $display("FAIL late_a_rd got %h want %h", a_rd, exp_a_rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic wb, ok, exp_b;
    step; rst = 1'b1;
    step; rst = 1'b0;
    exp_a_rd = 16'h0; exp_b_rd = 16'h0;
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    b_req = 1; b_we = 0; b_addr = 16'h0030;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp_b = (k % 2) == 1;
`else
      exp_b = 1'b0;
`endif
      if (k > 0) begin
        sb_pop(wb, ok);
        total_cnt++; if ({ok, a_ack, b_ack} !== (wb ? 3'b101 : 3'b110)) $display("FAIL b2b_ack%0d got %b want %b", k, {ok, a_ack, b_ack}, (wb ? 3'b101 : 3'b110)); else pass_cnt++;
        total_cnt++; if ({a_rd, b_rd} !== {exp_a_rd, exp_b_rd}) $display("FAIL b2b_rd%0d got %h want %h", k, {a_rd, b_rd}, {exp_a_rd, exp_b_rd}); else pass_cnt++;
      end
      total_cnt++; if ({a_gnt, b_gnt} !== (exp_b ? 2'b01 : 2'b10)) $display("FAIL b2b_grant%0d got %b want %b", k, {a_gnt, b_gnt}, (exp_b ? 2'b01 : 2'b10)); else pass_cnt++;
      sb_push(exp_b, 1'b1, exp_b ? 16'h5555 : 16'h1234);
      step;
      total_cnt++; if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL b2b_gap1_%0d got %b want 00", k, {a_gnt, b_gnt}); else pass_cnt++;
      step;
      total_cnt++; if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL b2b_gap2_%0d got %b want 00", k, {a_gnt, b_gnt}); else pass_cnt++;
      @(posedge clk); #1;
    end
    a_req = 0; b_req = 0;
    #1;
    sb_pop(wb, ok);
    total_cnt++; if ({ok, a_ack, b_ack} !== (wb ? 3'b101 : 3'b110)) $display("FAIL b2b_ack_last got %b want %b", {ok, a_ack, b_ack}, (wb ? 3'b101 : 3'b110)); else pass_cnt++;
    total_cnt++; if ({a_rd, b_rd} !== {exp_a_rd, exp_b_rd}) $display("FAIL b2b_rd_last got %h want %h", {a_rd, b_rd}, {exp_a_rd, exp_b_rd}); else pass_cnt++;
    total_cnt++; if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL b2b_grant_end got %b want 00", {a_gnt, b_gnt}); else pass_cnt++;
  endtask

  task automatic test_reset_abort;
    logic wb, ok;
    step;
    a_req = 1; a_we = 1; a_addr = 16'h0040; a_data = 16'h7777;
    #1;
    total_cnt++; if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL abort_grant got %b want 10", {a_gnt, b_gnt}); else pass_cnt++;
    step; a_req = 0; #1;
    total_cnt++; if (mem_we !== 1'b1) $display("FAIL abort_we_pre got %b want 1", mem_we); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL abort_we_cut got %b want 0", mem_we); else pass_cnt++;
    total_cnt++; if ({mem_addr, mem_wdata} !== 32'h0) $display("FAIL abort_mem got %h want 0", {mem_addr, mem_wdata}); else pass_cnt++;
    exp_a_rd = 16'h0; exp_b_rd = 16'h0;
    step; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      total_cnt++; if ({a_ack, b_ack} !== 2'b00) $display("FAIL abort_ack%0d got %b want 00", i, {a_ack, b_ack}); else pass_cnt++;
      total_cnt++; if ({a_rd, b_rd} !== {exp_a_rd, exp_b_rd}) $display("FAIL abort_rd%0d got %h want %h", i, {a_rd, b_rd}, {exp_a_rd, exp_b_rd}); else pass_cnt++;
    end
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    #1;
    total_cnt++; if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL abort_idle_grant got %b want 10", {a_gnt, b_gnt}); else pass_cnt++;
    sb_push(1'b0, 1'b1, 16'h1234);
    step; a_req = 0;
    step;
    step;
    sb_pop(wb, ok);
    total_cnt++; if ({ok, a_ack, b_ack} !== (wb ? 3'b101 : 3'b110)) $display("FAIL abort_post_ack got %b want %b", {ok, a_ack, b_ack}, (wb ? 3'b101 : 3'b110)); else pass_cnt++;
    total_cnt++; if ({a_rd, b_rd} !== {exp_a_rd, exp_b_rd}) $display("FAIL abort_post_rd got %h want %h", {a_rd, b_rd}, {exp_a_rd, exp_b_rd}); else pass_cnt++;
  endtask

  task automatic test_idle;
    a_req = 0; b_req = 0;
    for (int i = 0; i < 10; i++) begin
      step;
      total_cnt++; if ({a_gnt, b_gnt, a_ack, b_ack, mem_we} !== 5'b0) $display("FAIL idle_ctl%0d got %b want 00000", i, {a_gnt, b_gnt, a_ack, b_ack, mem_we}); else pass_cnt++;
      total_cnt++; if ({mem_addr, mem_wdata} !== 32'h0) $display("FAIL idle_mem%0d got %h want 0", i, {mem_addr, mem_wdata}); else pass_cnt++;
    end
    total_cnt++; if (sb_q.size() !== 0) $display("FAIL sb_leftover got %0d want 0", sb_q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_late_req;
    test_back_to_back;
    test_reset_abort;
    test_idle;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
